// File: rtl/ssp_rx_logic.sv
// SSP serial receiver: synchronizes the link signals into PCLK, deserializes MSB-first
// 8-bit frames delimited by an FSS pulse, and posts each word with a write or overrun strobe.
module ssp_rx_logic (
    input  logic       PCLK,
    input  logic       CLEAR,
    input  logic       SSPCLKIN,
    input  logic       SSPFSSIN,
    input  logic       SSPRXD,
    input  logic       RxFull,
    output logic [7:0] RxData,
    output logic       NextWord,
    output logic       SSPRXOVR,
    output logic       RxBusy
);

    typedef enum logic {IDLE, SHIFT} state_e;

    logic       clk_s1_q, clk_s2_q, clk_prev_q;
    logic       fss_s1_q, fss_s2_q;
    logic       rxd_s1_q, rxd_s2_q;
    logic       rise;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       next_word_q, next_word_d;
    logic       overrun_q, overrun_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge PCLK) begin
        if (CLEAR) begin
            clk_s1_q   <= 1'b0;
            clk_s2_q   <= 1'b0;
            clk_prev_q <= 1'b0;
            fss_s1_q   <= 1'b0;
            fss_s2_q   <= 1'b0;
            rxd_s1_q   <= 1'b0;
            rxd_s2_q   <= 1'b0;
        end else begin
            clk_s1_q   <= SSPCLKIN;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            fss_s1_q   <= SSPFSSIN;
            fss_s2_q   <= fss_s1_q;
            rxd_s1_q   <= SSPRXD;
            rxd_s2_q   <= rxd_s1_q;
        end
    end

    assign rise = clk_s2_q & ~clk_prev_q;

    always_ff @(posedge PCLK) begin
        if (CLEAR) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            next_word_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            next_word_q <= next_word_d;
            overrun_q   <= overrun_d;
        end
    end

    // NOTE: every variable gets a default first so this block cannot infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        next_word_d = 1'b0;
        overrun_d   = 1'b0;
        if (rise) begin
            case (state_q)
                IDLE: begin
                    if (fss_s2_q) begin
                        state_d = SHIFT;
                        cnt_d   = 3'd0;
                    end
                end
                default: begin
                    // FSS on the final bit is a legal back-to-back sync, not a framing error.
                    if (fss_s2_q && cnt_q != 3'd0 && cnt_q != 3'd7) begin
                        cnt_d   = 3'd0;
                        shift_d = 8'h00;
                    end else begin
                        shift_d = {shift_q[6:0], rxd_s2_q};
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            if (RxFull) begin
                                overrun_d = 1'b1;
                            end else begin
                                rx_data_d   = {shift_q[6:0], rxd_s2_q};
                                next_word_d = 1'b1;
                            end
                            if (!fss_s2_q) state_d = IDLE;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        RxBusy   = (state_q == SHIFT);
        RxData   = rx_data_q;
        NextWord = next_word_q;
        SSPRXOVR = overrun_q;
    end

endmodule

// File: tb/tb_ssp_rx_logic.sv
// Bench for ssp_rx_logic: directed bit-level vector table, hand-written reset corner
// cases, then randomized frames checked against a queue-based frame model.
module tb_ssp_rx_logic;

    logic       PCLK = 1'b0;
    logic       CLEAR, SSPCLKIN, SSPFSSIN, SSPRXD, RxFull;
    logic [7:0] RxData;
    logic       NextWord, SSPRXOVR, RxBusy;

    ssp_rx_logic dut (
        .PCLK     (PCLK),
        .CLEAR    (CLEAR),
        .SSPCLKIN (SSPCLKIN),
        .SSPFSSIN (SSPFSSIN),
        .SSPRXD   (SSPRXD),
        .RxFull   (RxFull),
        .RxData   (RxData),
        .NextWord (NextWord),
        .SSPRXOVR (SSPRXOVR),
        .RxBusy   (RxBusy)
    );

    always #5 PCLK = ~PCLK;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       fss;
        logic       rxd;
        logic       full;
        logic       nw;
        logic       ovr;
        logic [7:0] data;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    // Frame-level reference: a receiver is either hunting for sync or collecting bits.
    bit         m_busy = 1'b0;
    bit         m_bits[$];
    logic [7:0] m_data = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_bits.delete();
        m_data = 8'h00;
    endtask

    task automatic model_rise(input logic fss, input logic rxd, input logic full,
                              output logic nw, output logic ovr);
        int w;
        nw  = 1'b0;
        ovr = 1'b0;
        if (!m_busy) begin
            if (fss) begin
                m_busy = 1'b1;
                m_bits.delete();
            end
        end else if (fss && m_bits.size() >= 1 && m_bits.size() <= 6) begin
            m_bits.delete();
        end else begin
            m_bits.push_back(rxd);
            if (m_bits.size() == 8) begin
                w = 0;
                foreach (m_bits[i]) w = w * 2 + int'(m_bits[i]);
                if (full) ovr = 1'b1;
                else begin
                    nw     = 1'b1;
                    m_data = 8'(w);
                end
                m_bits.delete();
                m_busy = fss;
            end
        end
    endtask

    // One serial bit period; observes the strobes on every PCLK of the high phase.
    task automatic serial_bit(input logic fss, input logic rxd, input logic full,
                              output logic [7:0] nw_v, output logic [7:0] ovr_v,
                              output logic [7:0] data, output logic busy);
        int lo, hi;
        lo = $urandom_range(4, 6);
        hi = $urandom_range(4, 6);
        SSPFSSIN = fss;
        SSPRXD   = rxd;
        RxFull   = full;
        repeat (lo) @(posedge PCLK);
        #1;
        SSPCLKIN = 1'b1;
        nw_v  = 8'h00;
        ovr_v = 8'h00;
        data  = 8'h00;
        busy  = 1'b0;
        for (int i = 0; i < hi; i++) begin
            @(posedge PCLK);
            #1;
            nw_v[i]  = NextWord;
            ovr_v[i] = SSPRXOVR;
            if (i == 2) begin
                data = RxData;
                busy = RxBusy;
            end
        end
        SSPCLKIN = 1'b0;
    endtask

    // A strobe must appear only in the cycle after the third PCLK edge following the rise.
    task automatic cmp(input string name, input logic [7:0] nw_v, input logic [7:0] ovr_v,
                       input logic [7:0] data, input logic busy,
                       input logic e_nw, input logic e_ovr, input logic [7:0] e_data,
                       input logic e_busy);
        check({name, "_pulses"}, {nw_v, ovr_v},
              {(e_nw ? 8'h04 : 8'h00), (e_ovr ? 8'h04 : 8'h00)});
        check({name, "_rxdata"}, data, e_data);
        check({name, "_busy"}, busy, e_busy);
    endtask

    task automatic step_model(input string name, input logic fss, input logic rxd,
                              input logic full);
        logic       e_nw, e_ovr, b;
        logic [7:0] nv, ov, d;
        model_rise(fss, rxd, full, e_nw, e_ovr);
        serial_bit(fss, rxd, full, nv, ov, d, b);
        cmp(name, nv, ov, d, b, e_nw, e_ovr, m_data, m_busy);
    endtask

    task automatic model_frame(input string name, input logic [7:0] w, input logic full);
        step_model({name, "_sync"}, 1'b1, 1'b0, full);
        for (int i = 7; i >= 0; i--)
            step_model($sformatf("%s_b%0d", name, i), 1'b0, w[i], full);
    endtask

    task automatic push(input logic fss, input logic rxd, input logic full, input logic nw,
                        input logic ovr, input logic [7:0] data, input logic busy);
        vecs.push_back('{fss, rxd, full, nw, ovr, data, busy});
    endtask

    task automatic push_frame(input logic [7:0] w, input logic full, input logic fss_last,
                              input logic [7:0] prior, input logic sync);
        logic last;
        if (sync) push(1'b1, 1'b0, full, 1'b0, 1'b0, prior, 1'b1);
        for (int i = 7; i >= 0; i--) begin
            last = (i == 0);
            push(last ? fss_last : 1'b0, w[i], full, last && !full, last && full,
                 (last && !full) ? w : prior, last ? fss_last : 1'b1);
        end
    endtask

    task automatic check_idle_outputs(input string name, input logic e_busy);
        check({name, "_rxdata"}, RxData, 8'h00);
        check({name, "_nextword"}, NextWord, 1'b0);
        check({name, "_overrun"}, SSPRXOVR, 1'b0);
        check({name, "_busy"}, RxBusy, e_busy);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, limit 1000000 ns");
        $fatal(1);
    end

    initial begin
        logic [7:0] nv, ov, d;
        logic       b, dn, dovr;
        logic [7:0] rnd;

        CLEAR    = 1'b1;
        SSPCLKIN = 1'b0;
        SSPFSSIN = 1'b0;
        SSPRXD   = 1'b0;
        RxFull   = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        check_idle_outputs("reset", 1'b0);
        CLEAR = 1'b0;

        push_frame(8'hA5, 1'b0, 1'b0, 8'h00, 1'b1);
        push_frame(8'h3C, 1'b0, 1'b1, 8'hA5, 1'b1);
        push_frame(8'hC3, 1'b0, 1'b0, 8'h3C, 1'b0);
        push_frame(8'h5A, 1'b1, 1'b0, 8'hC3, 1'b1);
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b1);
        push(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b1);
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b1);
        push(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b1);
        push(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b1);
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b1);
        push_frame(8'h81, 1'b0, 1'b0, 8'hC3, 1'b0);
        for (int i = 0; i < 20; i++)
            push(1'b0, 1'(i % 2), 1'b0, 1'b0, 1'b0, 8'h81, 1'b0);

        foreach (vecs[i]) begin
            serial_bit(vecs[i].fss, vecs[i].rxd, vecs[i].full, nv, ov, d, b);
            model_rise(vecs[i].fss, vecs[i].rxd, vecs[i].full, dn, dovr);
            cmp($sformatf("vec%0d", i), nv, ov, d, b,
                vecs[i].nw, vecs[i].ovr, vecs[i].data, vecs[i].busy);
        end

        // Reset in the middle of a frame drops the partial word.
        step_model("midrst_sync", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            step_model($sformatf("midrst_b%0d", i), 1'b0, 1'b1, 1'b0);
        @(posedge PCLK);
        #1;
        CLEAR = 1'b1;
        @(posedge PCLK);
        #1;
        CLEAR = 1'b0;
        model_reset();
        check_idle_outputs("midrst_after", 1'b0);
        model_frame("ff", 8'hFF, 1'b0);
        check("ff_final_rxdata", RxData, 8'hFF);

        // Bit clock held high across reset release: spurious rise with FSS low is ignored.
        SSPFSSIN = 1'b0;
        repeat (4) @(posedge PCLK);
        #1;
        SSPCLKIN = 1'b1;
        CLEAR    = 1'b1;
        repeat (2) @(posedge PCLK);
        #1;
        CLEAR = 1'b0;
        model_reset();
        repeat (5) @(posedge PCLK);
        #1;
        check_idle_outputs("clkhigh_fss0", 1'b0);
        SSPCLKIN = 1'b0;
        repeat (4) @(posedge PCLK);
        #1;

        // Same with FSS high: the spurious rise is a valid sync.
        SSPFSSIN = 1'b1;
        repeat (4) @(posedge PCLK);
        #1;
        SSPCLKIN = 1'b1;
        CLEAR    = 1'b1;
        repeat (2) @(posedge PCLK);
        #1;
        CLEAR = 1'b0;
        model_reset();
        m_busy = 1'b1;
        repeat (5) @(posedge PCLK);
        #1;
        check_idle_outputs("clkhigh_fss1", 1'b1);
        SSPCLKIN = 1'b0;
        rnd = 8'($urandom);
        for (int i = 7; i >= 0; i--)
            step_model($sformatf("clkhigh_b%0d", i), 1'b0, rnd[i], 1'b0);

        for (int i = 0; i < 400; i++)
            step_model($sformatf("rnd%0d", i), $urandom_range(0, 7) == 0,
                       1'($urandom), $urandom_range(0, 3) == 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
